vector_packer: RTL and testbench

Serial-to-parallel packer that sits directly upstream of the max-element stage. It accepts neuron outputs one element per handshake and assembles them into a packed ELEMENT_COUNT-wide vector. It then presents that vector, held stable, to the downstream consumer until the consumer accepts it. It supports early termination with zero padding, a synchronous clear, and a sticky short-vector flag.

---
 rtl/vector_packer.sv | 50 +++++
 tb/tb_vector_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_packer.sv
// vector_packer: serial-to-parallel element packer that holds each packed vector until the consumer accepts it
module vector_packer #(
  parameter int ELEMENT_SIZE = 32,
  parameter int ELEMENT_COUNT = 10
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic [ELEMENT_SIZE-1:0]               in_data,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  output logic                                  in_ready,
  output logic [ELEMENT_SIZE*ELEMENT_COUNT-1:0] vec_out,
  output logic                                  vec_valid,
  input  logic                                  vec_ready,
  output logic [$clog2(ELEMENT_COUNT+1)-1:0]    count,
  output logic                                  err_short
);
  localparam int CW = $clog2(ELEMENT_COUNT + 1);
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_nxt;
  logic in_acc, vec_acc, at_end;
  assign in_ready = state == FILL;
  assign vec_valid = state == FULL;
  assign in_acc = in_valid && in_ready;
  assign vec_acc = vec_valid && vec_ready;
  assign at_end = count == CW'(ELEMENT_COUNT - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = clear ? FILL : (in_acc && (in_last || at_end)) ? FULL : vec_acc ? FILL : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec_out <= '0;
      count <= '0;
      err_short <= 1'b0;
    end else if (clear || vec_acc) begin
      vec_out <= '0;
      count <= '0;
      if (clear) err_short <= 1'b0;
    end else if (in_acc) begin
      for (int i = 0; i < ELEMENT_COUNT; i++)
        if (count == CW'(i)) vec_out[i*ELEMENT_SIZE +: ELEMENT_SIZE] <= in_data;
      count <= count + 1'b1;
      if (in_last && !at_end) err_short <= 1'b1;
    end
endmodule

// File: tb/tb_vector_packer.sv
// tb_vector_packer: randomized self-checking bench for vector_packer against a queue-based packing model
module tb_vector_packer;
  localparam int ES = 32;
  localparam int EC = 10;
  localparam int CW = $clog2(EC + 1);
  typedef logic [ES-1:0] elem_t;
  typedef logic [ES*EC-1:0] vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic vec_ready = 1'b0;
  elem_t in_data = '0;
  logic in_ready, vec_valid, err_short;
  vec_t vec_out;
  logic [CW-1:0] count;
  int total = 0;
  int bad = 0;
  elem_t flat[4*EC];
  int lens[4];

  vector_packer #(.ELEMENT_SIZE(ES), .ELEMENT_COUNT(EC)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .count(count), .err_short(err_short)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic vec_t pack(input elem_t e[$]);
    vec_t v = '0;
    foreach (e[i]) v = v | (vec_t'(e[i]) << (i * ES));
    return v;
  endfunction

  task automatic send(input elem_t d, input logic l);
    int n;
    n = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%0b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic take();
    int n;
    n = 0;
    vec_ready = 1'b1;
    while (!vec_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!vec_valid) begin
      total++; bad++;
      $display("FAIL take_timeout vec_valid=%0b want=1", vec_valid);
    end
    @(posedge clk); #1;
    vec_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL rst_vec_valid got=%0b want=0", vec_valid); end
    total++; if (vec_out !== '0) begin bad++; $display("FAIL rst_vec_out got=%h want=0", vec_out); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", err_short); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    elem_t d[$] = '{87, 45, 66, 29, 133, 42, 16, 100, 187, 53};
    vec_t exp;
    exp = pack(d);
    for (int i = 0; i < EC; i++) begin
      send(d[i], 1'b0);
      if (i == EC - 2) begin
        total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%0b want=0", vec_valid); end
      end
    end
    total++; if (vec_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b want=1", vec_valid); end
    total++; if (vec_out !== exp) begin bad++; $display("FAIL full_vec got=%h want=%h", vec_out, exp); end
    total++; if (count !== CW'(EC)) begin bad++; $display("FAIL full_count got=%0d want=%0d", count, EC); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
    repeat (5) begin
      @(posedge clk); #1;
      total++; if (vec_out !== exp || vec_valid !== 1'b1) begin bad++; $display("FAIL full_hold got=%h/%0b want=%h/1", vec_out, vec_valid, exp); end
    end
  endtask

  task automatic test_refill();
    elem_t d[$] = '{897, 4995, 2663, 2669, 1373, 4222, 146, 10340, 13487, 3453};
    vec_t exp;
    exp = pack(d);
    take();
    total++; if (vec_out !== '0) begin bad++; $display("FAIL refill_zero got=%h want=0", vec_out); end
    total++; if (in_ready !== 1'b1 || vec_valid !== 1'b0) begin bad++; $display("FAIL refill_state got=%0b/%0b want=1/0", in_ready, vec_valid); end
    foreach (d[i]) send(d[i], 1'b0);
    total++; if (vec_out !== exp) begin bad++; $display("FAIL refill_vec got=%h want=%h", vec_out, exp); end
    total++; if (count !== CW'(EC)) begin bad++; $display("FAIL refill_count got=%0d want=%0d", count, EC); end
  endtask

  task automatic test_short();
    elem_t d[$] = '{5, 9, 7};
    elem_t r[$];
    vec_t exp;
    take();
    send(5, 1'b0);
    send(9, 1'b0);
    send(7, 1'b1);
    exp = pack(d);
    total++; if (vec_out !== exp) begin bad++; $display("FAIL short_vec got=%h want=%h", vec_out, exp); end
    total++; if (count !== CW'(3)) begin bad++; $display("FAIL short_count got=%0d want=3", count); end
    total++; if (err_short !== 1'b1) begin bad++; $display("FAIL short_err got=%0b want=1", err_short); end
    total++; if (vec_valid !== 1'b1) begin bad++; $display("FAIL short_valid got=%0b want=1", vec_valid); end
    take();
    for (int i = 0; i < EC; i++) begin
      r.push_back(elem_t'($urandom));
      send(r[i], i == EC - 1);
    end
    exp = pack(r);
    total++; if (vec_out !== exp) begin bad++; $display("FAIL short_next_vec got=%h want=%h", vec_out, exp); end
    total++; if (err_short !== 1'b1) begin bad++; $display("FAIL short_sticky got=%0b want=1", err_short); end
    total++; if (count !== CW'(EC)) begin bad++; $display("FAIL short_next_count got=%0d want=%0d", count, EC); end
  endtask

  task automatic test_clear();
    elem_t r[$];
    vec_t exp;
    take();
    repeat (4) send(elem_t'($urandom), 1'b0);
    in_data = 123;
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    total++; if (count !== '0) begin bad++; $display("FAIL clr_count got=%0d want=0", count); end
    total++; if (vec_out !== '0) begin bad++; $display("FAIL clr_vec got=%h want=0", vec_out); end
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL clr_err got=%0b want=0", err_short); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%0b want=0", vec_valid); end
    r.push_back(77);
    send(77, 1'b0);
    exp = pack(r);
    total++; if (vec_out !== exp || count !== CW'(1)) begin bad++; $display("FAIL clr_slot0 got=%h/%0d want=%h/1", vec_out, count, exp); end
    for (int i = 1; i < EC; i++) begin
      r.push_back(elem_t'($urandom));
      send(r[i], 1'b0);
    end
    exp = pack(r);
    total++; if (vec_out !== exp) begin bad++; $display("FAIL clr_refill got=%h want=%h", vec_out, exp); end
    vec_ready = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    clear = 1'b0;
    total++; if (vec_valid !== 1'b0 || vec_out !== '0) begin bad++; $display("FAIL clr_full got=%0b/%h want=0/0", vec_valid, vec_out); end
  endtask

  task automatic test_async_reset();
    elem_t r[$];
    vec_t exp;
    repeat (6) send(elem_t'($urandom), 1'b0);
    total++; if (count !== CW'(6)) begin bad++; $display("FAIL arst_pre_count got=%0d want=6", count); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== '0 || vec_out !== '0) begin bad++; $display("FAIL arst_data got=%0d/%h want=0/0", count, vec_out); end
    total++; if (in_ready !== 1'b1 || vec_valid !== 1'b0 || err_short !== 1'b0) begin bad++; $display("FAIL arst_flags got=%0b/%0b/%0b want=1/0/0", in_ready, vec_valid, err_short); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < EC; i++) begin
      r.push_back(elem_t'($urandom));
      send(r[i], 1'b0);
    end
    exp = pack(r);
    total++; if (vec_out !== exp || count !== CW'(EC)) begin bad++; $display("FAIL arst_refill got=%h/%0d want=%h/%0d", vec_out, count, exp, EC); end
  endtask

  task automatic consume(input int nvec, input logic check_err);
    int n;
    logic exp_err;
    elem_t s[$];
    vec_t exp;
    exp_err = 1'b0;
    for (int v = 0; v < nvec; v++) begin
      n = 0;
      while (!vec_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      s.delete();
      for (int k = 0; k < lens[v]; k++) s.push_back(flat[v*EC + k]);
      exp = pack(s);
      if (lens[v] < EC) exp_err = 1'b1;
      total++; if (vec_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_full%0d got=%0b/%0b want=1/0", v, vec_valid, in_ready); end
      repeat ($urandom_range(1, 4)) begin
        total++; if (vec_out !== exp) begin bad++; $display("FAIL bp_vec%0d got=%h want=%h", v, vec_out, exp); end
        @(posedge clk); #1;
      end
      total++; if (vec_out !== exp || count !== CW'(lens[v])) begin bad++; $display("FAIL bp_final%0d got=%h/%0d want=%h/%0d", v, vec_out, count, exp, lens[v]); end
      if (check_err) begin
        total++; if (err_short !== exp_err) begin bad++; $display("FAIL rnd_err%0d got=%0b want=%0b", v, err_short, exp_err); end
      end
      vec_ready = 1'b1;
      @(posedge clk); #1;
      vec_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    take();
    for (int i = 0; i < 2*EC; i++) flat[i] = elem_t'($urandom);
    lens[0] = EC;
    lens[1] = EC;
    fork
      for (int i = 0; i < 2*EC; i++) send(flat[i], 1'b0);
      consume(2, 1'b0);
    join
  endtask

  task automatic test_random();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int v = 0; v < 4; v++) begin
      lens[v] = $urandom_range(1, EC);
      for (int k = 0; k < EC; k++) flat[v*EC + k] = elem_t'($urandom);
    end
    fork
      for (int v = 0; v < 4; v++)
        for (int k = 0; k < lens[v]; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(flat[v*EC + k], k == lens[v] - 1);
        end
      consume(4, 1'b1);
    join
  endtask

  initial begin
    test_reset();
    test_full();
    test_refill();
    test_short();
    test_clear();
    test_async_reset();
    test_backpressure();
    repeat (3) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
